// File: rtl/fpga2_burst_receiver.sv
// FPGA-2 inter-chip burst receiver: req/rdy/ack handshake, toggle-strobed words, FIFO drained over valid/ready.
// Latency: req->rdy SYNC_STAGES+2, word_tgl->FIFO write SYNC_STAGES+1, send_done->ack/nack SYNC_STAGES+1; a word is dropped (sticky overflow) only if the FIFO is full with no pop.
module fpga2_burst_receiver #(
   parameter int DATA_W        = 32,
   parameter int FIFO_DEPTH    = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int RECEIVE_COUNT = 10,
   parameter int CNT_W         = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          req_in,
   input  logic                          word_tgl,
   input  logic                          send_done,
   output logic                          rdy_out,
   output logic                          ack_out,
   output logic                          nack_out,
   output logic [DATA_W-1:0]             m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [CNT_W-1:0]              word_count,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READY   = 3'd1,
      RECEIVE = 3'd2,
      ACK     = 3'd3,
      NACK    = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
   logic [SYNC_STAGES-1:0] tgl_sync_q, tgl_sync_d;
   logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
   logic                   tgl_d_q, tgl_d_d;
   logic [AW:0]            wr_ptr_q, wr_ptr_d;
   logic [AW:0]            rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];

   state_t                 state_q;
   logic                   rdy_q, ack_q, nack_q, ovf_q;
   logic [CNT_W-1:0]       cnt_q;

   logic                   req_s, tgl_s, done_s, word_ev;
   logic [AW:0]            level;
   logic                   empty, full, pop, push_req, push, drop;
   logic [CNT_W-1:0]       cnt_final;
   logic                   ovf_final, len_ok;

   always_comb begin
      req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_in};
      tgl_sync_d  = {tgl_sync_q[SYNC_STAGES-2:0], word_tgl};
      done_sync_d = {done_sync_q[SYNC_STAGES-2:0], send_done};
      req_s       = req_sync_q[SYNC_STAGES-1];
      tgl_s       = tgl_sync_q[SYNC_STAGES-1];
      done_s      = done_sync_q[SYNC_STAGES-1];
      tgl_d_d     = tgl_s;
      word_ev     = tgl_s ^ tgl_d_q;
   end

   always_comb begin
      level    = wr_ptr_q - rd_ptr_q;
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (level == (AW+1)'(FIFO_DEPTH));
      pop      = !empty && m_ready;
      push_req = (state_q == RECEIVE) && word_ev;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // The exit decision must see the word arriving in the same cycle.
   always_comb begin
      cnt_final = cnt_q;
      if (push_req && (cnt_q != {CNT_W{1'b1}}))
         cnt_final = cnt_q + CNT_W'(1);
      ovf_final = ovf_q || drop;
      len_ok    = (RECEIVE_COUNT == 0) || (cnt_final == CNT_W'(RECEIVE_COUNT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_sync_q  <= '0;
         tgl_sync_q  <= '0;
         done_sync_q <= '0;
         tgl_d_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         req_sync_q  <= req_sync_d;
         tgl_sync_q  <= tgl_sync_d;
         done_sync_q <= done_sync_d;
         tgl_d_q     <= tgl_d_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rdy_q  <= 1'b0;
               ack_q  <= 1'b0;
               nack_q <= 1'b0;
               if (req_s)
                  state_q <= READY;
            end
            READY: begin
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
               rdy_q   <= 1'b1;
               state_q <= RECEIVE;
            end
            RECEIVE: begin
               cnt_q <= cnt_final;
               ovf_q <= ovf_final;
               if (done_s) begin
                  rdy_q <= 1'b0;
                  if (len_ok && !ovf_final) begin
                     ack_q   <= 1'b1;
                     state_q <= ACK;
                  end else begin
                     nack_q  <= 1'b1;
                     state_q <= NACK;
                  end
               end else if (!req_s) begin
                  rdy_q   <= 1'b0;
                  nack_q  <= 1'b1;
                  state_q <= NACK;
               end
            end
            ACK, NACK: begin
               if (!req_s && !done_s) begin
                  ack_q   <= 1'b0;
                  nack_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               rdy_q   <= 1'b0;
               ack_q   <= 1'b0;
               nack_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rdy_out    = rdy_q;
   assign ack_out    = ack_q;
   assign nack_out   = nack_q;
   assign word_count = cnt_q;
   assign overflow   = ovf_q;
   assign fifo_level = level;
   assign m_valid    = !empty;
   assign m_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_fpga2_burst_receiver.sv
// Directed bench: one receiver with a 16-deep FIFO and one with a 4-deep FIFO for overflow and wrap cases.
module tb_fpga2_burst_receiver;

   localparam int S = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic [1:0]  req_v, tgl_v, done_v, mrdy_v;
   logic [1:0]  rdy_v, ack_v, nack_v, mval_v, ovf_v;
   logic [15:0] wc_v [2];
   logic [31:0] md_v [2];
   logic [4:0]  lvl_v [2];
   logic [4:0]  lvl16;
   logic [2:0]  lvl4;

   int checks;
   int failures;

   fpga2_burst_receiver #(
      .DATA_W(32), .FIFO_DEPTH(16), .SYNC_STAGES(S), .RECEIVE_COUNT(10), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .req_in(req_v[0]), .word_tgl(tgl_v[0]), .send_done(done_v[0]),
      .rdy_out(rdy_v[0]), .ack_out(ack_v[0]), .nack_out(nack_v[0]),
      .m_data(md_v[0]), .m_valid(mval_v[0]), .m_ready(mrdy_v[0]),
      .word_count(wc_v[0]), .overflow(ovf_v[0]), .fifo_level(lvl16)
   );

   fpga2_burst_receiver #(
      .DATA_W(32), .FIFO_DEPTH(4), .SYNC_STAGES(S), .RECEIVE_COUNT(6), .CNT_W(16)
   ) u_dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .req_in(req_v[1]), .word_tgl(tgl_v[1]), .send_done(done_v[1]),
      .rdy_out(rdy_v[1]), .ack_out(ack_v[1]), .nack_out(nack_v[1]),
      .m_data(md_v[1]), .m_valid(mval_v[1]), .m_ready(mrdy_v[1]),
      .word_count(wc_v[1]), .overflow(ovf_v[1]), .fifo_level(lvl4)
   );

   assign lvl_v[0] = lvl16;
   assign lvl_v[1] = {2'b00, lvl4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_burst(input int sel);
      req_v[sel] = 1'b1;
      tick(S + 1);
      check("rdy_early", 32'(rdy_v[sel]), 0);
      tick(1);
      check("rdy_rise", 32'(rdy_v[sel]), 1);
      check("wc_clear", 32'(wc_v[sel]), 0);
      check("ovf_clear", 32'(ovf_v[sel]), 0);
   endtask

   task automatic send_word(input int sel, input logic [31:0] val);
      data_in    = val;
      tgl_v[sel] = ~tgl_v[sel];
      tick(S + 3);
   endtask

   task automatic end_burst(input int sel, input logic exp_ack, input int exp_wc);
      done_v[sel] = 1'b1;
      tick(S);
      check("resp_early", 32'(ack_v[sel] | nack_v[sel]), 0);
      tick(1);
      check("ack", 32'(ack_v[sel]), 32'(exp_ack));
      check("nack", 32'(nack_v[sel]), 32'(!exp_ack));
      check("rdy_fall", 32'(rdy_v[sel]), 0);
      check("wc_final", 32'(wc_v[sel]), 32'(exp_wc));
      req_v[sel]  = 1'b0;
      done_v[sel] = 1'b0;
      tick(S + 2);
      check("resp_release", 32'(ack_v[sel] | nack_v[sel]), 0);
   endtask

   task automatic pop_expect(input int sel, input logic [31:0] val);
      check("pop_valid", 32'(mval_v[sel]), 1);
      check("pop_data", md_v[sel], val);
      mrdy_v[sel] = 1'b1;
      tick(1);
      mrdy_v[sel] = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      data_in  = '0;
      req_v    = '0;
      tgl_v    = '0;
      done_v   = '0;
      mrdy_v   = '0;
      #12;
      check("rst_rdy", 32'(rdy_v[0]), 0);
      check("rst_ack", 32'(ack_v[0] | nack_v[0]), 0);
      check("rst_valid", 32'(mval_v[0]), 0);
      check("rst_level", 32'(lvl_v[0]), 0);
      check("rst_data", md_v[0], 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // Nominal burst of 10 words into the deep FIFO.
      start_burst(0);
      data_in  = 32'h1;
      tgl_v[0] = ~tgl_v[0];
      tick(S);
      check("mval_early", 32'(mval_v[0]), 0);
      tick(1);
      check("mval_rise", 32'(mval_v[0]), 1);
      check("first_data", md_v[0], 32'h1);
      tick(2);
      for (int i = 2; i <= 10; i++) send_word(0, 32'(i));
      check("nom_level", 32'(lvl_v[0]), 10);
      end_burst(0, 1'b1, 10);
      for (int i = 1; i <= 10; i++) pop_expect(0, 32'(i));
      check("nom_empty", 32'(mval_v[0]), 0);
      check("nom_empty_data", md_v[0], 0);

      // Length mismatch: 9 words.
      start_burst(0);
      for (int i = 1; i <= 9; i++) send_word(0, 32'h20 + 32'(i));
      end_burst(0, 1'b0, 9);
      check("mis_ovf", 32'(ovf_v[0]), 0);
      for (int i = 1; i <= 9; i++) pop_expect(0, 32'h20 + 32'(i));
      check("mis_empty", 32'(mval_v[0]), 0);

      // Abort: requester drops req mid-burst.
      start_burst(0);
      for (int i = 1; i <= 3; i++) send_word(0, 32'h30 + 32'(i));
      req_v[0] = 1'b0;
      tick(S + 1);
      check("abort_rdy", 32'(rdy_v[0]), 0);
      check("abort_nack", 32'(nack_v[0]), 1);
      check("abort_ack", 32'(ack_v[0]), 0);
      check("abort_wc", 32'(wc_v[0]), 3);
      tick(1);
      check("abort_idle", 32'(nack_v[0]), 0);
      for (int i = 1; i <= 3; i++) pop_expect(0, 32'h30 + 32'(i));
      start_burst(0);
      for (int i = 1; i <= 10; i++) send_word(0, 32'h10 + 32'(i));
      end_burst(0, 1'b1, 10);

      // Overflow on the 4-deep FIFO: 6 words with no draining.
      start_burst(1);
      for (int i = 1; i <= 6; i++) send_word(1, 32'h40 + 32'(i));
      end_burst(1, 1'b0, 6);
      check("ovf_level", 32'(lvl_v[1]), 4);
      check("ovf_flag", 32'(ovf_v[1]), 1);
      for (int i = 1; i <= 4; i++) pop_expect(1, 32'h40 + 32'(i));
      check("ovf_drained", 32'(mval_v[1]), 0);

      // Full FIFO with push and pop in the same cycle, across pointer wrap.
      start_burst(1);
      for (int i = 1; i <= 4; i++) send_word(1, 32'h50 + 32'(i));
      check("pp_full", 32'(lvl_v[1]), 4);
      data_in  = 32'h55;
      tgl_v[1] = ~tgl_v[1];
      tick(S);
      mrdy_v[1] = 1'b1;
      tick(1);
      mrdy_v[1] = 1'b0;
      check("pp_level", 32'(lvl_v[1]), 4);
      check("pp_ovf", 32'(ovf_v[1]), 0);
      tick(2);
      end_burst(1, 1'b0, 5);
      check("pp_ovf_end", 32'(ovf_v[1]), 0);
      for (int i = 2; i <= 5; i++) pop_expect(1, 32'h50 + 32'(i));
      check("pp_empty", 32'(mval_v[1]), 0);

      // Async reset while receiving.
      start_burst(0);
      send_word(0, 32'h61);
      send_word(0, 32'h62);
      check("pre_rst_wc", 32'(wc_v[0]), 2);
      check("pre_rst_level", 32'(lvl_v[0]), 12);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rdy", 32'(rdy_v[0]), 0);
      check("arst_wc", 32'(wc_v[0]), 0);
      check("arst_valid", 32'(mval_v[0]), 0);
      check("arst_level", 32'(lvl_v[0]), 0);
      check("arst_data", md_v[0], 0);
      req_v[0] = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(S + 3);
      check("post_rst_valid", 32'(mval_v[0]), 0);
      check("post_rst_rdy", 32'(rdy_v[0]), 0);
      check("post_rst_resp", 32'(ack_v[0] | nack_v[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
